// File: rtl/ad9866_pkg.sv
// Shared types and constants for the AD9866 SPI responder: frame layout,
// well-known register addresses and the frame FSM states.
package ad9866_pkg;

  typedef struct packed {
    logic       rw;
    logic [1:0] pad;
    logic [4:0] addr;
    logic [7:0] data;
  } ad9866_frame_t;

  localparam logic [4:0] ADDR_RX_GAIN = 5'h09;
  localparam logic [4:0] ADDR_TX_GAIN = 5'h0A;
  localparam int         FRAME_BITS   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ad9866_state_t;

endpackage

// File: rtl/ad9866_spi_responder_sync.sv
// Optional input synchroniser for sclk/sen_n/sdio plus the sclk rising-edge
// and sen_n rising/falling-edge detectors; sclk is sampled as data on clk.
module ad9866_spi_sync_edge #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic sen_n,
  input  logic sdio,
  output logic sdio_s,
  output logic rise_s,
  output logic sen_fall_s,
  output logic sen_rise_s
);

  logic sclk_s;
  logic sen_n_s;
  logic sclk_q;
  logic sen_n_q;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign sclk_s  = sclk;
      assign sen_n_s = sen_n;
      assign sdio_s  = sdio;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sclk_sync_r;
      logic [SYNC_STAGES-1:0] sen_sync_r;
      logic [SYNC_STAGES-1:0] sdio_sync_r;

      // Multi-flop synchroniser chains for an asynchronous initiator
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sclk_sync_r <= '0;
          sen_sync_r  <= '0;
          sdio_sync_r <= '0;
        end else begin
          sclk_sync_r[0] <= sclk;
          sen_sync_r[0]  <= sen_n;
          sdio_sync_r[0] <= sdio;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sclk_sync_r[i] <= sclk_sync_r[i-1];
            sen_sync_r[i]  <= sen_sync_r[i-1];
            sdio_sync_r[i] <= sdio_sync_r[i-1];
          end
        end
      end

      assign sclk_s  = sclk_sync_r[SYNC_STAGES-1];
      assign sen_n_s = sen_sync_r[SYNC_STAGES-1];
      assign sdio_s  = sdio_sync_r[SYNC_STAGES-1];
    end
  endgenerate

  // Previous-sample history; sen_n_q resets low so a frame already in
  // progress at reset release cannot look like a fresh falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q  <= 1'b0;
      sen_n_q <= 1'b0;
    end else begin
      sclk_q  <= sclk_s;
      sen_n_q <= sen_n_s;
    end
  end

  assign rise_s     = sclk_s & ~sclk_q;
  assign sen_fall_s = ~sen_n_s & sen_n_q;
  assign sen_rise_s = sen_n_s & ~sen_n_q;

endmodule

// File: rtl/ad9866_spi_responder.sv
// AD9866 configuration-port responder: decodes 16-bit SPI frames into a
// shadow register file. Define AD9866_RESP_RDBK_EN to enable read-back on sdo.
module ad9866_spi_responder
  import ad9866_pkg::*;
#(
  parameter int SYNC_STAGES = 0,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              sen_n,
  input  logic              sdio,
  output logic              sdo,
  output logic              sdo_oe,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [5:0]        rx_gain,
  output logic [5:0]        tx_gain,
  output logic              frame_err
);

  logic sdio_s;
  logic rise_s;
  logic sen_fall_s;
  logic sen_rise_s;

  ad9866_spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .sen_n     (sen_n),
    .sdio      (sdio),
    .sdio_s    (sdio_s),
    .rise_s    (rise_s),
    .sen_fall_s(sen_fall_s),
    .sen_rise_s(sen_rise_s)
  );

  ad9866_state_t     state_r;
  ad9866_state_t     state_nxt_s;
  logic [4:0]        bitcnt_r;
  logic [15:0]       shift_r;
  logic [15:0]       shift_nxt_s;
  ad9866_frame_t     frame_s;
  logic [ADDR_W-1:0] addr_s;
  logic              shift_en_s;
  logic              last_bit_s;
  logic              commit_s;
  logic              abort_s;
  logic              unused_s;

  logic [7:0]        regs_r [2**ADDR_W];
  logic              wr_stb_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [7:0]        wr_data_r;
  logic [5:0]        rx_gain_r;
  logic [5:0]        tx_gain_r;
  logic              frame_err_r;

  // sen_n deassertion beats a coincident sclk rise, so it blocks shifting
  assign shift_nxt_s = {shift_r[14:0], sdio_s};
  assign frame_s     = ad9866_frame_t'(shift_nxt_s);
  assign addr_s      = ADDR_W'(frame_s.addr);
  assign shift_en_s  = (state_r == ST_SHIFT) && rise_s && !sen_rise_s;
  assign last_bit_s  = shift_en_s && (bitcnt_r == 5'(FRAME_BITS - 1));
  assign commit_s    = last_bit_s && !frame_s.rw;
  assign abort_s     = (state_r == ST_SHIFT) && sen_rise_s;
  assign unused_s    = ^{frame_s.pad, shift_r[15]};

  // Frame FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sen_fall_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sen_rise_s) begin
          state_nxt_s = ST_IDLE;
        end else if (last_bit_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (sen_rise_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, bit counter and input shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      bitcnt_r <= 5'd0;
      shift_r  <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_IDLE) begin
        bitcnt_r <= 5'd0;
      end else if (shift_en_s) begin
        bitcnt_r <= bitcnt_r + 5'd1;
      end
      if (shift_en_s) begin
        shift_r <= shift_nxt_s;
      end
    end
  end

  // Shadow register file, written only by a completed write frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (commit_s) begin
      regs_r[addr_s] <= frame_s.data;
    end
  end

  // Write strobe, last-write capture, gain shadows and abort pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_stb_r    <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= 8'h00;
      rx_gain_r   <= 6'h00;
      tx_gain_r   <= 6'h00;
      frame_err_r <= 1'b0;
    end else begin
      wr_stb_r    <= commit_s;
      frame_err_r <= abort_s;
      if (commit_s) begin
        wr_addr_r <= addr_s;
        wr_data_r <= frame_s.data;
      end
      if (commit_s && (addr_s == ADDR_W'(ADDR_RX_GAIN))) begin
        rx_gain_r <= frame_s.data[5:0];
      end
      if (commit_s && (addr_s == ADDR_W'(ADDR_TX_GAIN))) begin
        tx_gain_r <= frame_s.data[5:0];
      end
    end
  end

  assign wr_stb    = wr_stb_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign rx_gain   = rx_gain_r;
  assign tx_gain   = tx_gain_r;
  assign frame_err = frame_err_r;

`ifdef AD9866_RESP_RDBK_EN
  logic              addr_done_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [7:0]        sdo_sr_r;
  logic              sdo_oe_r;

  // After 8 bits the address sits in the low byte of the shift register
  assign addr_done_s = shift_en_s && (bitcnt_r == 5'd7);
  assign rd_addr_s   = ADDR_W'(shift_nxt_s[4:0]);

  // Read data shifter: loaded when addressing completes, advanced per rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdo_sr_r <= 8'h00;
      sdo_oe_r <= 1'b0;
    end else if (addr_done_s && shift_nxt_s[7]) begin
      sdo_sr_r <= regs_r[rd_addr_s];
      sdo_oe_r <= 1'b1;
    end else if (last_bit_s || abort_s || (state_r != ST_SHIFT)) begin
      sdo_sr_r <= 8'h00;
      sdo_oe_r <= 1'b0;
    end else if (shift_en_s && sdo_oe_r) begin
      sdo_sr_r <= {sdo_sr_r[6:0], 1'b0};
    end
  end

  assign sdo    = sdo_sr_r[7];
  assign sdo_oe = sdo_oe_r;
`else
  assign sdo    = 1'b0;
  assign sdo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// Directed, table-driven bench for ad9866_spi_responder (same-domain and
// 2-stage synchronised instances); read checks follow AD9866_RESP_RDBK_EN.
module tb_ad9866_spi_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk0, sen_n0, sdio0, sdo0, sdo_oe0, wr_stb0, frame_err0;
  logic [4:0] wr_addr0;
  logic [7:0] wr_data0;
  logic [5:0] rx_gain0, tx_gain0;
  logic       sclk2, sen_n2, sdio2, sdo2, sdo_oe2, wr_stb2, frame_err2;
  logic [4:0] wr_addr2;
  logic [7:0] wr_data2;
  logic [5:0] rx_gain2, tx_gain2;

  int n_tests = 0;
  int n_fail  = 0;
  int stb_cnt0 = 0;
  int err_cnt0 = 0;
  int stb_cnt2 = 0;

  logic [7:0] model [32];

  typedef struct {
    logic [15:0] frame;
    logic [4:0]  exp_addr;
    logic [7:0]  exp_data;
  } vec_t;
  vec_t vecs [12];

`ifdef AD9866_RESP_RDBK_EN
  localparam logic [7:0]  EXP_RD  = 8'h41;
  localparam logic [15:0] EXP_OE  = 16'h00FF;
`else
  localparam logic [7:0]  EXP_RD  = 8'h00;
  localparam logic [15:0] EXP_OE  = 16'h0000;
`endif

  always #5 clk = ~clk;

  ad9866_spi_responder #(.SYNC_STAGES(0), .ADDR_W(5)) dut0 (
    .clk(clk), .reset(reset), .sclk(sclk0), .sen_n(sen_n0), .sdio(sdio0),
    .sdo(sdo0), .sdo_oe(sdo_oe0), .wr_stb(wr_stb0), .wr_addr(wr_addr0),
    .wr_data(wr_data0), .rx_gain(rx_gain0), .tx_gain(tx_gain0),
    .frame_err(frame_err0)
  );

  ad9866_spi_responder #(.SYNC_STAGES(2), .ADDR_W(5)) dut2 (
    .clk(clk), .reset(reset), .sclk(sclk2), .sen_n(sen_n2), .sdio(sdio2),
    .sdo(sdo2), .sdo_oe(sdo_oe2), .wr_stb(wr_stb2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .rx_gain(rx_gain2), .tx_gain(tx_gain2),
    .frame_err(frame_err2)
  );

  always @(posedge clk) begin
    if (wr_stb0)    stb_cnt0 <= stb_cnt0 + 1;
    if (frame_err0) err_cnt0 <= err_cnt0 + 1;
    if (wr_stb2)    stb_cnt2 <= stb_cnt2 + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input bit sel2, input logic c, input logic e, input logic d);
    if (sel2) begin
      sclk2 = c; sen_n2 = e; sdio2 = d;
    end else begin
      sclk0 = c; sen_n0 = e; sdio0 = d;
    end
  endtask

  // Drives nbits of f; fewer than 16 bits ends as an abort. Samples sdo/sdo_oe
  // just before each sclk rise, as the initiator would.
  task automatic spi_frame(input logic [15:0] f, input int nbits, input int hp,
                           input int gap, input bit sel2,
                           output logic [7:0] rd, output logic [15:0] oe_map);
    logic s_sdo, s_oe;
    rd = 8'h00;
    oe_map = 16'h0000;
    set_pins(sel2, 1'b0, 1'b0, 1'b0);
    tick(hp);
    for (int i = 0; i < nbits; i++) begin
      set_pins(sel2, 1'b0, 1'b0, f[15-i]);
      tick(hp);
      s_sdo = sel2 ? sdo2 : sdo0;
      s_oe  = sel2 ? sdo_oe2 : sdo_oe0;
      oe_map[15-i] = s_oe;
      if (s_oe) rd = {rd[6:0], s_sdo};
      set_pins(sel2, 1'b1, 1'b0, f[15-i]);
      tick(hp);
    end
    set_pins(sel2, 1'b0, 1'b0, 1'b0);
    tick(hp);
    set_pins(sel2, 1'b0, 1'b1, 1'b0);
    tick(gap);
  endtask

  task automatic check_file(input string tag);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s_reg%02h", tag, i), {24'h0, dut0.regs_r[i]}, {24'h0, model[i]});
    end
  endtask

  initial begin
    logic [7:0]  rd;
    logic [15:0] oe_map;
    int          s0, e0, s2;

    vecs[0]  = '{16'h0080, 5'h00, 8'h80};
    vecs[1]  = '{16'h0436, 5'h04, 8'h36};
    vecs[2]  = '{16'h0501, 5'h05, 8'h01};
    vecs[3]  = '{16'h0654, 5'h06, 8'h54};
    vecs[4]  = '{16'h0721, 5'h07, 8'h21};
    vecs[5]  = '{16'h084B, 5'h08, 8'h4B};
    vecs[6]  = '{16'h0920, 5'h09, 8'h20};
    vecs[7]  = '{16'h0A47, 5'h0A, 8'h47};
    vecs[8]  = '{16'h0B00, 5'h0B, 8'h00};
    vecs[9]  = '{16'h0C41, 5'h0C, 8'h41};
    vecs[10] = '{16'h0E81, 5'h0E, 8'h81};
    vecs[11] = '{16'h1100, 5'h11, 8'h00};
    for (int i = 0; i < 32; i++) model[i] = 8'h00;

    reset = 1'b1;
    set_pins(1'b0, 1'b0, 1'b1, 1'b0);
    set_pins(1'b1, 1'b0, 1'b1, 1'b0);
    tick(3);
    reset = 1'b0;
    tick(3);
    check("rst_sdo",     {31'h0, sdo0},      32'h0);
    check("rst_sdo_oe",  {31'h0, sdo_oe0},   32'h0);
    check("rst_wr_stb",  {31'h0, wr_stb0},   32'h0);
    check("rst_ferr",    {31'h0, frame_err0}, 32'h0);
    check("rst_wr_addr", {27'h0, wr_addr0},  32'h0);
    check("rst_wr_data", {24'h0, wr_data0},  32'h0);
    check("rst_rx_gain", {26'h0, rx_gain0},  32'h0);
    check("rst_tx_gain", {26'h0, tx_gain0},  32'h0);
    check("rst_err_cnt", err_cnt0,           32'h0);

    // Single write to rx gain register
    s0 = stb_cnt0;
    spi_frame(16'h0941, 16, 2, 3, 1'b0, rd, oe_map);
    model[9] = 8'h41;
    check("w09_stb_cnt", stb_cnt0 - s0,      32'd1);
    check("w09_wr_addr", {27'h0, wr_addr0},  32'h09);
    check("w09_wr_data", {24'h0, wr_data0},  32'h41);
    check("w09_rx_gain", {26'h0, rx_gain0},  32'h01);
    check("w09_tx_gain", {26'h0, tx_gain0},  32'h00);
    check("w09_oe_map",  {16'h0, oe_map},    32'h0);
    check_file("w09");

    // Write 0x0C then read it back
    spi_frame(16'h0C41, 16, 2, 3, 1'b0, rd, oe_map);
    model[12] = 8'h41;
    s0 = stb_cnt0;
    spi_frame(16'h8C00, 16, 2, 3, 1'b0, rd, oe_map);
    check("rd_data",     {24'h0, rd},        {24'h0, EXP_RD});
    check("rd_oe_map",   {16'h0, oe_map},    {16'h0, EXP_OE});
    check("rd_no_stb",   stb_cnt0 - s0,      32'd0);
    check("rd_sdo_idle", {30'h0, sdo0, sdo_oe0}, 32'h0);
    check("rd_wr_addr",  {27'h0, wr_addr0},  32'h0C);

    // Abort after 10 bits of a tx gain write
    s0 = stb_cnt0;
    e0 = err_cnt0;
    spi_frame(16'h0A3F, 10, 2, 3, 1'b0, rd, oe_map);
    check("abort_ferr",  err_cnt0 - e0,      32'd1);
    check("abort_stb",   stb_cnt0 - s0,      32'd0);
    check("abort_tx",    {26'h0, tx_gain0},  32'h00);
    check_file("abort");

    // Back-to-back initialisation sequence, sen_n high for one clk between
    s0 = stb_cnt0;
    e0 = err_cnt0;
    for (int i = 0; i < 12; i++) begin
      spi_frame(vecs[i].frame, 16, 2, 1, 1'b0, rd, oe_map);
      model[vecs[i].exp_addr] = vecs[i].exp_data;
      check($sformatf("init%0d_addr", i), {27'h0, wr_addr0}, {27'h0, vecs[i].exp_addr});
      check($sformatf("init%0d_data", i), {24'h0, wr_data0}, {24'h0, vecs[i].exp_data});
    end
    tick(2);
    check("init_stb_cnt", stb_cnt0 - s0,     32'd12);
    check("init_no_ferr", err_cnt0 - e0,     32'd0);
    check("init_rx_gain", {26'h0, rx_gain0}, 32'h20);
    check("init_tx_gain", {26'h0, tx_gain0}, 32'h07);
    check_file("init");

    // Reset in the middle of a frame (after 5 bits)
    set_pins(1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    for (int i = 0; i < 5; i++) begin
      set_pins(1'b0, 1'b0, 1'b0, 1'b1);
      tick(2);
      set_pins(1'b0, 1'b1, 1'b0, 1'b1);
      tick(2);
    end
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    check("mid_rst_rx",   {26'h0, rx_gain0}, 32'h00);
    check("mid_rst_addr", {27'h0, wr_addr0}, 32'h00);
    set_pins(1'b0, 1'b0, 1'b1, 1'b0);
    tick(3);
    s0 = stb_cnt0;
    e0 = err_cnt0;
    spi_frame(16'h0A15, 16, 2, 3, 1'b0, rd, oe_map);
    model[10] = 8'h15;
    check("post_rst_tx",   {26'h0, tx_gain0}, 32'h15);
    check("post_rst_rx",   {26'h0, rx_gain0}, 32'h00);
    check("post_rst_stb",  stb_cnt0 - s0,     32'd1);
    check("post_rst_ferr", err_cnt0 - e0,     32'd0);
    check_file("post_rst");

    // Synchronised instance, sclk = clk/8
    s2 = stb_cnt2;
    spi_frame(16'h0A2A, 16, 4, 4, 1'b1, rd, oe_map);
    tick(4);
    check("sync2_tx",   {26'h0, tx_gain2}, 32'h2A);
    check("sync2_stb",  stb_cnt2 - s2,     32'd1);
    check("sync2_addr", {27'h0, wr_addr2}, 32'h0A);
    check("sync2_data", {24'h0, wr_data2}, 32'h2A);
    check("sync2_ferr", {31'h0, frame_err2}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
